// File: rtl/soc_system_onchip_mem_pkg.sv
// Shared types and constants for the dual-port on-chip RAM.
// Optional feature: ONCHIP_MEM_OUTREG_EN adds a registered read stage.
package soc_system_onchip_mem_pkg;

    typedef enum logic [0:0] {
        PRIO_S1 = 1'b0,
        PRIO_S2 = 1'b1
    } prio_e;

`ifdef ONCHIP_MEM_OUTREG_EN
    localparam int READ_LATENCY = 2;
`else
    localparam int READ_LATENCY = 1;
`endif

    function automatic bit params_ok(
        input int dw,
        input int bs,
        input int aw,
        input int depth
    );
        return (bs > 0) && (dw > 0) && (dw % bs == 0) &&
               (aw > 0) && (aw < 32) && (depth > 0) &&
               (longint'(depth) <= (longint'(1) << aw));
    endfunction

endpackage

// File: rtl/soc_system_onchip_memory_dp_if.sv
// Avalon-MM slave bundle for one RAM port.
// Ports: address/byteenable/chipselect/read/write/writedata in,
// readdata/readdatavalid/waitrequest out (seen from the slave).
interface soc_system_onchip_memory_dp_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4
);
    logic [ADDR_WIDTH-1:0] address;
    logic [BE_WIDTH-1:0]   byteenable;
    logic                  chipselect;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;
    logic                  waitrequest;

    modport master (
        output address, byteenable, chipselect, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/soc_system_onchip_mem_rdpipe.sv
// Per-port read pipeline: valid shift register, out-of-range mask,
// readdata gating. ONCHIP_MEM_OUTREG_EN adds an output data register.
// Ports: clk, reset, freeze, rd_acc, oor, q in; readdata, readdatavalid out.
module soc_system_onchip_mem_rdpipe
    import soc_system_onchip_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  freeze,
    input  logic                  rd_acc,
    input  logic                  oor,
    input  logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  readdatavalid
);

    logic [READ_LATENCY-1:0] vld;
    logic                    oor_q;
    logic [DATA_WIDTH-1:0]   ram_d;

    // oor_q tracks the address that produced the current RAM q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld   <= '0;
            oor_q <= 1'b0;
        end else if (!freeze) begin
            vld   <= READ_LATENCY'({vld, rd_acc});
            oor_q <= oor;
        end
    end

    assign ram_d         = oor_q ? '0 : q;
    assign readdatavalid = vld[READ_LATENCY-1] & ~freeze;

`ifdef ONCHIP_MEM_OUTREG_EN
    logic [DATA_WIDTH-1:0] data_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r <= '0;
        end else if (!freeze) begin
            data_r <= vld[0] ? ram_d : '0;
        end
    end

    assign readdata = readdatavalid ? data_r : '0;
`else
    assign readdata = readdatavalid ? ram_d : '0;
`endif

endmodule

// File: rtl/soc_system_onchip_memory_dp.sv
// True dual-port on-chip RAM with two Avalon-MM slaves (s1, s2).
// Ports: clk, reset, clken, reset_req, s1/s2 (slave bundles), err_oor.
// Optional: ONCHIP_MEM_OUTREG_EN selects a two-cycle read latency.
module soc_system_onchip_memory_dp
    import soc_system_onchip_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_SIZE  = 8,
    parameter int ADDR_WIDTH = 17,
    parameter int DEPTH      = 112500,
    parameter     INIT_FILE  = "soc_system_onchip_memory2_0.hex"
) (
    input  logic clk,
    input  logic reset,
    input  logic clken,
    input  logic reset_req,
    soc_system_onchip_memory_dp_if.slave s1,
    soc_system_onchip_memory_dp_if.slave s2,
    output logic err_oor
);

    localparam int NBE = DATA_WIDTH / BYTE_SIZE;

    if (!params_ok(DATA_WIDTH, BYTE_SIZE, ADDR_WIDTH, DEPTH)) begin : g_bad
        $error("soc_system_onchip_memory_dp: illegal parameters");
    end

    // The power-on image is bound by the vendor RAM flow; an empty
    // name leaves the contents uninitialised.
    if (INIT_FILE == "") begin : g_no_init
    end

    logic  freeze;
    logic  cmd1, cmd2;
    logic  rng1, rng2;
    logic  conflict;
    logic  acc1, acc2;
    prio_e prio;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] q1, q2;

    assign freeze = ~clken | reset_req;

    assign cmd1 = s1.chipselect & (s1.read | s1.write);
    assign cmd2 = s2.chipselect & (s2.read | s2.write);
    assign rng1 = int'(s1.address) < DEPTH;
    assign rng2 = int'(s2.address) < DEPTH;

    // Read/read to one word is served on both ports at once.
    assign conflict = cmd1 & cmd2 & rng1 & rng2 &
                      (s1.address == s2.address) &
                      (s1.write | s2.write);

    assign s1.waitrequest = reset | freeze |
                            (conflict & (prio == PRIO_S2));
    assign s2.waitrequest = reset | freeze |
                            (conflict & (prio == PRIO_S1));

    assign acc1 = cmd1 & ~s1.waitrequest;
    assign acc2 = cmd2 & ~s2.waitrequest;

    // Hand priority to the loser so repeated conflicts alternate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio <= PRIO_S1;
        end else if (!freeze && conflict) begin
            prio <= (prio == PRIO_S1) ? PRIO_S2 : PRIO_S1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_oor <= 1'b0;
        end else if ((acc1 & ~rng1) | (acc2 & ~rng2)) begin
            err_oor <= 1'b1;
        end
    end

    // Arbitration guarantees the two write ports never hit one word.
    // Nonblocking reads give old data on same-cycle read/write.
    always_ff @(posedge clk) begin
        if (!freeze) begin
            if (acc1 & s1.write & rng1) begin
                for (int b = 0; b < NBE; b++) begin
                    if (s1.byteenable[b]) begin
                        mem[s1.address][b*BYTE_SIZE +: BYTE_SIZE] <=
                            s1.writedata[b*BYTE_SIZE +: BYTE_SIZE];
                    end
                end
            end
            if (acc2 & s2.write & rng2) begin
                for (int b = 0; b < NBE; b++) begin
                    if (s2.byteenable[b]) begin
                        mem[s2.address][b*BYTE_SIZE +: BYTE_SIZE] <=
                            s2.writedata[b*BYTE_SIZE +: BYTE_SIZE];
                    end
                end
            end
            q1 <= mem[s1.address];
            q2 <= mem[s2.address];
        end
    end

    soc_system_onchip_mem_rdpipe #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rdpipe1 (
        .clk           (clk),
        .reset         (reset),
        .freeze        (freeze),
        .rd_acc        (acc1 & s1.read),
        .oor           (~rng1),
        .q             (q1),
        .readdata      (s1.readdata),
        .readdatavalid (s1.readdatavalid)
    );

    soc_system_onchip_mem_rdpipe #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rdpipe2 (
        .clk           (clk),
        .reset         (reset),
        .freeze        (freeze),
        .rd_acc        (acc2 & s2.read),
        .oor           (~rng2),
        .q             (q2),
        .readdata      (s2.readdata),
        .readdatavalid (s2.readdatavalid)
    );

endmodule

// File: tb/tb_soc_system_onchip_memory_dp.sv
// Directed self-checking bench for soc_system_onchip_memory_dp.
// Honours ONCHIP_MEM_OUTREG_EN for the expected read latency.
`timescale 1ns/1ps
module tb_soc_system_onchip_memory_dp;

`ifdef ONCHIP_MEM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    logic clken;
    logic reset_req;
    logic err_oor;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    soc_system_onchip_memory_dp_if #(
        .ADDR_WIDTH (17),
        .DATA_WIDTH (32),
        .BE_WIDTH   (4)
    ) bus1 ();

    soc_system_onchip_memory_dp_if #(
        .ADDR_WIDTH (17),
        .DATA_WIDTH (32),
        .BE_WIDTH   (4)
    ) bus2 ();

    soc_system_onchip_memory_dp dut (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .reset_req (reset_req),
        .s1        (bus1),
        .s2        (bus2),
        .err_oor   (err_oor)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input int p, input bit rd, input bit wr,
                       input logic [16:0] a, input logic [31:0] d,
                       input logic [3:0] be);
        if (p == 1) begin
            bus1.chipselect = 1'b1;
            bus1.read       = rd;
            bus1.write      = wr;
            bus1.address    = a;
            bus1.writedata  = d;
            bus1.byteenable = be;
        end else begin
            bus2.chipselect = 1'b1;
            bus2.read       = rd;
            bus2.write      = wr;
            bus2.address    = a;
            bus2.writedata  = d;
            bus2.byteenable = be;
        end
    endtask

    task automatic idle(input int p);
        if (p == 1) begin
            bus1.chipselect = 1'b0;
            bus1.read       = 1'b0;
            bus1.write      = 1'b0;
            bus1.address    = '0;
            bus1.writedata  = '0;
            bus1.byteenable = '0;
        end else begin
            bus2.chipselect = 1'b0;
            bus2.read       = 1'b0;
            bus2.write      = 1'b0;
            bus2.address    = '0;
            bus2.writedata  = '0;
            bus2.byteenable = '0;
        end
    endtask

    // lat = cycles after the accept edge; 0 means the bound expired.
    task automatic wait_valid(input int p, output int lat,
                              output logic [31:0] d);
        logic v;
        lat = 0;
        d   = '0;
        for (int i = 1; i <= 12; i++) begin
            #1;
            v = (p == 1) ? bus1.readdatavalid : bus2.readdatavalid;
            if (v) begin
                lat = i;
                d   = (p == 1) ? bus1.readdata : bus2.readdata;
                break;
            end
            cyc();
        end
    endtask

    task automatic do_write(input int p, input logic [16:0] a,
                            input logic [31:0] d, input logic [3:0] be);
        cmd(p, 1'b0, 1'b1, a, d, be);
        cyc();
        idle(p);
    endtask

    task automatic do_read(input int p, input logic [16:0] a,
                           input logic [31:0] exp, input string tag);
        int          lat;
        logic [31:0] d;
        cmd(p, 1'b1, 1'b0, a, '0, '0);
        cyc();
        idle(p);
        wait_valid(p, lat, d);
        check({tag, "_lat"}, 64'(lat), 64'(LAT));
        check(tag, 64'(d), 64'(exp));
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] d;

        reset     = 1'b1;
        clken     = 1'b1;
        reset_req = 1'b0;
        idle(1);
        idle(2);
        repeat (3) @(posedge clk);
        #2;
        check("rst_s1_wait", 64'(bus1.waitrequest), 64'd1);
        check("rst_s2_wait", 64'(bus2.waitrequest), 64'd1);
        check("rst_s1_valid", 64'(bus1.readdatavalid), 64'd0);
        check("rst_s2_data", 64'(bus2.readdata), 64'd0);
        check("rst_err_oor", 64'(err_oor), 64'd0);
        cyc();
        reset = 1'b0;
        #1;
        check("idle_s1_wait", 64'(bus1.waitrequest), 64'd0);
        check("idle_s2_wait", 64'(bus2.waitrequest), 64'd0);
        cyc();

        // Basic write then read on the other port
        do_write(1, 17'h10, 32'hDEADBEEF, 4'hF);
        do_read(2, 17'h10, 32'hDEADBEEF, "basic_rd");

        // Byte lanes
        do_write(1, 17'd5, 32'h11223344, 4'hF);
        do_write(1, 17'd5, 32'hAABBCCDD, 4'h5);
        do_read(1, 17'd5, 32'h11BB33DD, "byte_lanes");

        // Conflict: s1 wins first, then s2 wins the next one
        cmd(1, 1'b0, 1'b1, 17'd7, 32'h1, 4'hF);
        cmd(2, 1'b0, 1'b1, 17'd7, 32'h2, 4'hF);
        #1;
        check("cf1_s1_wait", 64'(bus1.waitrequest), 64'd0);
        check("cf1_s2_wait", 64'(bus2.waitrequest), 64'd1);
        cyc();
        cmd(1, 1'b1, 1'b0, 17'd7, '0, '0);
        #1;
        check("cf2_s1_wait", 64'(bus1.waitrequest), 64'd1);
        check("cf2_s2_wait", 64'(bus2.waitrequest), 64'd0);
        cyc();
        idle(2);
        #1;
        check("cf3_s1_wait", 64'(bus1.waitrequest), 64'd0);
        cyc();
        idle(1);
        wait_valid(1, lat, d);
        check("cf_rd_lat", 64'(lat), 64'(LAT));
        check("cf_rd_data", 64'(d), 64'h2);
        cyc();

        // Both ports read the same word: no stall, same cycle
        cmd(1, 1'b1, 1'b0, 17'h10, '0, '0);
        cmd(2, 1'b1, 1'b0, 17'h10, '0, '0);
        #1;
        check("rr_s1_wait", 64'(bus1.waitrequest), 64'd0);
        check("rr_s2_wait", 64'(bus2.waitrequest), 64'd0);
        cyc();
        idle(1);
        idle(2);
        wait_valid(1, lat, d);
        check("rr_s1_lat", 64'(lat), 64'(LAT));
        check("rr_s1_data", 64'(d), 64'hDEADBEEF);
        check("rr_s2_valid", 64'(bus2.readdatavalid), 64'd1);
        check("rr_s2_data", 64'(bus2.readdata), 64'hDEADBEEF);
        cyc();

        // Simultaneous writes to different words
        cmd(1, 1'b0, 1'b1, 17'd20, 32'hA5A5A5A5, 4'hF);
        cmd(2, 1'b0, 1'b1, 17'd21, 32'h5A5A5A5A, 4'hF);
        #1;
        check("ww_s1_wait", 64'(bus1.waitrequest), 64'd0);
        check("ww_s2_wait", 64'(bus2.waitrequest), 64'd0);
        cyc();
        idle(1);
        idle(2);
        do_read(2, 17'd20, 32'hA5A5A5A5, "ww_rd20");
        do_read(1, 17'd21, 32'h5A5A5A5A, "ww_rd21");

        // Out-of-range read and write
        check("pre_err_oor", 64'(err_oor), 64'd0);
        cmd(2, 1'b1, 1'b0, 17'd112500, '0, '0);
        #1;
        check("oor_s2_wait", 64'(bus2.waitrequest), 64'd0);
        cyc();
        idle(2);
        wait_valid(2, lat, d);
        check("oor_rd_lat", 64'(lat), 64'(LAT));
        check("oor_rd_data", 64'(d), 64'd0);
        check("oor_err", 64'(err_oor), 64'd1);
        cyc();
        do_write(1, 17'd120000, 32'hFFFFFFFF, 4'hF);
        do_read(1, 17'h10, 32'hDEADBEEF, "oor_keep10");
        do_read(2, 17'd5, 32'h11BB33DD, "oor_keep5");
        do_read(1, 17'd7, 32'h2, "oor_keep7");
        check("oor_err_sticky", 64'(err_oor), 64'd1);

        // clken low stalls both ports
        clken = 1'b0;
        cmd(1, 1'b1, 1'b0, 17'h10, '0, '0);
        #1;
        check("clken_s1_wait", 64'(bus1.waitrequest), 64'd1);
        check("clken_s2_wait", 64'(bus2.waitrequest), 64'd1);
        cyc();
        idle(1);
        clken = 1'b1;
        #1;
        check("clken_no_valid", 64'(bus1.readdatavalid), 64'd0);
        cyc();

        // Freeze for 3 cycles right after an accepted read
        cmd(1, 1'b1, 1'b0, 17'h10, '0, '0);
        cyc();
        idle(1);
        reset_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("frz_s1_wait", 64'(bus1.waitrequest), 64'd1);
            check("frz_s2_wait", 64'(bus2.waitrequest), 64'd1);
            check("frz_no_valid", 64'(bus1.readdatavalid), 64'd0);
            cyc();
        end
        reset_req = 1'b0;
        wait_valid(1, lat, d);
        check("frz_lat", 64'(lat), 64'(LAT));
        check("frz_data", 64'(d), 64'hDEADBEEF);
        cyc();

        // Reset right after an accepted read drops it
        cmd(1, 1'b1, 1'b0, 17'd5, '0, '0);
        cyc();
        idle(1);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mrst_no_valid", 64'(bus1.readdatavalid), 64'd0);
            check("mrst_wait", 64'(bus1.waitrequest), 64'd1);
            cyc();
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("post_rst_no_valid", 64'(bus1.readdatavalid), 64'd0);
            cyc();
        end
        check("post_rst_err", 64'(err_oor), 64'd0);
        do_read(1, 17'd5, 32'h11BB33DD, "post_rst_rd5");
        do_read(2, 17'h10, 32'hDEADBEEF, "post_rst_rd10");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
